// File: rtl/ram_sdp_param.sv
// ---------------------------------------------------------------------------
// ram_sdp_param
//
// Parametrised simple-dual-port synchronous RAM with one write port and one
// independent read port on a single clock. After every reset a clear
// sequencer walks the whole array and writes INIT_VAL to each word. While it
// runs, init_busy is high and every request is dropped.
//
// Parameters
//   DATA_W   : data word width in bits (>= 1)
//   ADDR_W   : address width, depth = 2**ADDR_W words
//   RDW_MODE : same-address read-during-write result
//              0 = old data (read-first), 1 = new data (write-first bypass)
//   INIT_VAL : value written to every word by the clear sequencer
//
// Optional feature (macro RAM_PARITY_EN)
//   Defined  : every word carries an even-parity bit. wr_par_flip inverts the
//              stored bit on an accepted write, for fault injection. Each read
//              reports rd_par_err alongside rd_data.
//   Undefined: no parity storage, rd_par_err is tied low, and wr_par_flip is
//              ignored. The port list is the same in both builds.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   wr_en       in   write request
//   wr_addr     in   [ADDR_W-1:0] write address
//   wr_data     in   [DATA_W-1:0] write data
//   wr_par_flip in   invert stored parity for this write (parity build only)
//   rd_en       in   read request
//   rd_addr     in   [ADDR_W-1:0] read address
//   rd_data     out  [DATA_W-1:0] registered read data
//   rd_valid    out  one-cycle strobe, rd_data was updated by the last edge
//   rd_par_err  out  parity mismatch on rd_data, qualified by rd_valid
//   init_busy   out  clear sequencer running, requests ignored
//
// Request/response semantics: there is no backpressure. When init_busy is
// low, a request on wr_en or rd_en is accepted at the rising edge where it is
// sampled. For a read accepted at edge N, rd_valid is high for exactly the
// cycle after edge N, and rd_data/rd_par_err hold the result. While init_busy
// is high, requests are dropped and not queued.
// ---------------------------------------------------------------------------
module ram_sdp_param #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_par_flip,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_par_err,
  output logic              init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef RAM_PARITY_EN
  // The parity bit is the top bit of each stored word.
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_par_err_q, rd_par_err_d;

  // The storage array has no reset. The clear sequencer defines its contents.
  logic [MEM_W-1:0]  mem [DEPTH];

  logic              wr_acc;
  logic              rd_acc;
  logic              bypass;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  clr_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wword;
  logic [MEM_W-1:0]  rd_src;

  // ---------------------------------------------------------------------
  // Word encoding: data plus optional even parity (inverted on demand)
  // ---------------------------------------------------------------------
`ifdef RAM_PARITY_EN
  assign wr_word  = {(^wr_data) ^ wr_par_flip, wr_data};
  assign clr_word = {^INIT_VAL, INIT_VAL};
`else
  logic unused_par_flip;
  assign unused_par_flip = wr_par_flip;
  assign wr_word         = wr_data;
  assign clr_word        = INIT_VAL;
`endif

  // ---------------------------------------------------------------------
  // Clear sequencer FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Clear sequencer FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        // The last address is written on this edge, so the array is fully
        // initialised when READY is entered.
        if (&clr_cnt_q) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign init_busy = (state_q != ST_READY);

  // ---------------------------------------------------------------------
  // Request acceptance and array write port
  // ---------------------------------------------------------------------
  assign wr_acc = wr_en && (state_q == ST_READY);
  assign rd_acc = rd_en && (state_q == ST_READY);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wword = wr_word;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wword = clr_word;
    end else if (wr_acc) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wword;
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // The array is read combinationally, before this edge's write lands. That
  // gives read-first behaviour. Write-first mode bypasses the incoming word
  // on a same-address collision, including its possibly-flipped parity.
  // ---------------------------------------------------------------------
  assign bypass = (RDW_MODE == 1) && wr_acc && (wr_addr == rd_addr);
  assign rd_src = bypass ? wr_word : mem[rd_addr];

  always_comb begin
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    rd_par_err_d = 1'b0;
    if (rd_acc) begin
      rd_data_d  = rd_src[DATA_W-1:0];
      rd_valid_d = 1'b1;
`ifdef RAM_PARITY_EN
      // Even parity over data and parity bit together: any set bit is an error.
      rd_par_err_d = ^rd_src;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_par_err_q <= 1'b0;
    end else begin
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_par_err_q <= rd_par_err_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_par_err = rd_par_err_q;

endmodule

// File: tb/tb_ram_sdp_param.sv
// ---------------------------------------------------------------------------
// tb_ram_sdp_param
//
// Bench for ram_sdp_param with DATA_W=8 and ADDR_W=6. RDW_MODE is a bench
// parameter. The reference model is a plain word array plus a per-word
// "parity was corrupted" flag. Each accepted read pushes {par_err, data} into
// exp_q. A negedge monitor pops and compares an entry whenever rd_valid is
// high. When rd_valid is low, the monitor checks that rd_data holds its value
// and that rd_par_err is low.
// ---------------------------------------------------------------------------
module tb_ram_sdp_param #(
  parameter int RDW_MODE = 0
);

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

`ifdef RAM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_par_flip = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_par_err;
  logic              init_busy;

  always #5 clk = ~clk;

  ram_sdp_param #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RDW_MODE(RDW_MODE),
    .INIT_VAL(8'h00)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_par_flip(wr_par_flip),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_par_err (rd_par_err),
    .init_busy  (init_busy)
  );

  // ---------------- model / scoreboard ----------------
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_err [DEPTH];
  logic [DATA_W:0]   exp_q [$];
  int                cyc;          // edges since rst_n last rose
  int                n_vec = 0;
  int                n_err = 0;
  logic [DATA_W-1:0] last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 8'h00;
      m_err[i] = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1. Sets up one cycle of requests, records the expected
  // behaviour, then advances past the next edge.
  task automatic cycle(input bit we, input int wa, input int wd, input bit fl,
                       input bit re, input int ra);
    bit acc;
    logic [DATA_W:0] e;
    acc         = (cyc >= DEPTH);
    wr_en       = we;
    wr_addr     = ADDR_W'(wa);
    wr_data     = DATA_W'(wd);
    wr_par_flip = fl;
    rd_en       = re;
    rd_addr     = ADDR_W'(ra);
    if (acc && re) begin
      if (we && (wa == ra) && (RDW_MODE == 1))
        e = {PAR_ON & fl, DATA_W'(wd)};
      else
        e = {PAR_ON & m_err[ra], m_mem[ra]};
      exp_q.push_back(e);
    end
    if (acc && we) begin
      m_mem[wa] = DATA_W'(wd);
      m_err[wa] = fl;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("init_busy", {31'd0, init_busy}, {31'd0, (cyc < DEPTH)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  // Drops rst_n asynchronously at posedge+1, checks the outputs right away,
  // and releases rst_n after hold edges.
  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    exp_q.delete();
    model_clear();
    #1;
    chk("rst_rd_data",    {24'd0, rd_data},    32'd0);
    chk("rst_rd_valid",   {31'd0, rd_valid},   32'd0);
    chk("rst_rd_par_err", {31'd0, rd_par_err}, 32'd0);
    chk("rst_init_busy",  {31'd0, init_busy},  32'd1);
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    if (!rst_n) begin
      last_data = '0;
    end else if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_valid_unexpected: got rd_valid=1 rd_data=0x%0h with no read pending at %0t",
                 rd_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data",    {24'd0, rd_data},    {24'd0, e[DATA_W-1:0]});
        chk("rd_par_err", {31'd0, rd_par_err}, {31'd0, e[DATA_W]});
      end
      last_data = rd_data;
    end else begin
      chk("rd_data_hold",    {24'd0, rd_data},    {24'd0, last_data});
      chk("rd_par_err_idle", {31'd0, rd_par_err}, 32'd0);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    cyc = 0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset(2);

    // Clear window with a read of address 5 held from the first cycle.
    for (int i = 0; i < DEPTH + 3; i++) cycle(0, 0, 0, 0, 1, 5);
    idle(2);

    // Write i for i = 0,10,...,60, then read the same addresses back-to-back.
    for (int i = 0; i <= 60; i += 10) cycle(1, i, i, 0, 0, 0);
    for (int i = 0; i <= 60; i += 10) cycle(0, 0, 0, 0, 1, i);
    idle(2);

    // Same-address collision.
    cycle(1, 20, 8'hAA, 0, 0, 0);
    cycle(1, 20, 8'h55, 0, 1, 20);
    cycle(0, 0, 0, 0, 1, 20);
    idle(2);

    // Parity fault injection.
    cycle(1, 7, 8'h0F, 1, 0, 0);
    cycle(1, 8, 8'hF0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 7);
    cycle(0, 0, 0, 0, 1, 8);
    idle(2);

    // Collision-free concurrency.
    cycle(1, 2, 8'h77, 0, 0, 0);
    cycle(1, 1, 8'h99, 0, 1, 2);
    cycle(0, 0, 0, 0, 1, 1);
    idle(2);

    // Random traffic, narrow address range to provoke collisions.
    for (int i = 0; i < 300; i++) begin
      int hi;
      hi = ($urandom_range(0, 3) == 0) ? DEPTH - 1 : 7;
      cycle($urandom_range(0, 1), $urandom_range(0, hi), $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, hi));
    end
    idle(2);

    // Reset mid-stream after writing address 63.
    cycle(1, 63, 8'h3C, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 63);
    cycle(1, 5, 8'h11, 0, 1, 63);
    do_reset(1);
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 0, 0, 1, 63);
    idle(2);

    // Reset in the middle of the clear sequence.
    cycle(1, 40, 8'hE7, 0, 0, 0);
    do_reset(1);
    idle(20);
    do_reset(1);
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 0, 0, 1, 40);
    idle(3);

    chk("pending_reads_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
